digi_ota_an: RTL and testbench

Digital emulation of an operational transconductance amplifier (OTA) driving a load capacitor, packaged as a Tiny Tapeout user tile.
- Differential input: vinp on ui_in, vinn on uio_in.
- Each enabled clock, a transconductance stage converts (vinp - vinn) into a signed, slew-limited charge step.
- An 8-bit saturating integrator (the "capacitor voltage") accumulates the step and drives uo_out.

---
 rtl/digi_ota_pkg.sv | 13 +
 rtl/ota_gm_stage.sv | 31 +++
 rtl/digi_ota_an.sv | 64 ++++++
 tb/tb_digi_ota_an.sv | 135 +++++++++++++
 4 files changed

// File: rtl/digi_ota_pkg.sv
// Shared widths, rails and default parameters for the digital OTA tile.
// No logic; constants only.
package digi_ota_pkg;
    localparam int DIFF_W = 9;
    localparam int SUM_W  = 10;

    localparam int VOUT_MIN = 0;
    localparam int VOUT_MAX = 255;

    localparam int GM_SHIFT_DEF   = 3;
    localparam int SLEW_MAX_DEF   = 16;
    localparam int VOUT_RESET_DEF = 128;
endpackage

// File: rtl/ota_gm_stage.sv
// Transconductance stage: (vinp - vinn) >>> GM_SHIFT, clamped to +/-SLEW_MAX.
// Purely combinational, zero latency; no flow control.
module ota_gm_stage
    import digi_ota_pkg::*;
#(
    parameter int GM_SHIFT = GM_SHIFT_DEF,
    parameter int SLEW_MAX = SLEW_MAX_DEF
) (
    input  logic        [7:0]        vinp_i,
    input  logic        [7:0]        vinn_i,
    output logic signed [DIFF_W-1:0] step_o
);
    localparam logic signed [DIFF_W-1:0] SLEW_P = DIFF_W'(SLEW_MAX);
    localparam logic signed [DIFF_W-1:0] SLEW_N = -SLEW_P;

    logic signed [DIFF_W-1:0] diff;
    logic signed [DIFF_W-1:0] shifted;

    // Arithmetic shift floors toward -inf, so small negative diffs still step by -1.
    assign diff    = $signed({1'b0, vinp_i}) - $signed({1'b0, vinn_i});
    assign shifted = diff >>> GM_SHIFT;

    always_comb begin
        step_o = shifted;
        if (shifted > SLEW_P) begin
            step_o = SLEW_P;
        end else if (shifted < SLEW_N) begin
            step_o = SLEW_N;
        end
    end
endmodule

// File: rtl/digi_ota_an.sv
// OTA driving a load cap: saturating 8-bit integrator of the gm-stage step.
// One-cycle latency input to uo_out; no backpressure, ena=0 simply holds.
module digi_ota_an
    import digi_ota_pkg::*;
#(
    parameter int GM_SHIFT   = GM_SHIFT_DEF,
    parameter int SLEW_MAX   = SLEW_MAX_DEF,
    parameter int VOUT_RESET = VOUT_RESET_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(VOUT_MIN);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(VOUT_MAX);

    logic        [7:0]        vout_q;
    logic        [7:0]        vout_d;
    logic signed [DIFF_W-1:0] step;
    logic signed [SUM_W-1:0]  sum;

    ota_gm_stage #(
        .GM_SHIFT (GM_SHIFT),
        .SLEW_MAX (SLEW_MAX)
    ) u_gm (
        .vinp_i (ui_in),
        .vinn_i (uio_in),
        .step_o (step)
    );

    // Widen before adding so the rails can be detected instead of wrapping.
    assign sum = $signed({2'b00, vout_q}) + $signed({step[DIFF_W-1], step});

    always_comb begin
        vout_d = vout_q;
        if (ena) begin
            if (sum < SUM_MIN) begin
                vout_d = 8'(VOUT_MIN);
            end else if (sum > SUM_MAX) begin
                vout_d = 8'(VOUT_MAX);
            end else begin
                vout_d = sum[7:0];
            end
        end
    end

    // rst_n is active-high on this tile.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            vout_q <= 8'(VOUT_RESET);
        end else begin
            vout_q <= vout_d;
        end
    end

    assign uo_out  = vout_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_digi_ota_an.sv
// Directed bench for digi_ota_an: reset, ramps, rails, floor asymmetry, hold, mid-run reset.
module tb_digi_ota_an;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    digi_ota_an dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        int e;
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'd37;
        uio_in = 8'd200;

        // Reset regardless of ena/inputs
        tick();
        chk("rst_vout_0", uo_out, 8'd128);
        ena = 1'b1; ui_in = 8'd255; uio_in = 8'd0;
        tick();
        chk("rst_vout_1", uo_out, 8'd128);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h00);

        // Linear ramp: diff 100 -> step 12
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'd200; uio_in = 8'd100;
        e = 128;
        for (int i = 0; i < 3; i++) begin
            tick();
            e += 12;
            chk("ramp", uo_out, 8'(e));
        end

        // Enable hold for 5 edges, then resume
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", uo_out, 8'd164);
        end
        ena = 1'b1;
        tick(); chk("resume_0", uo_out, 8'd176);
        tick(); chk("resume_1", uo_out, 8'd188);
        tick(); chk("resume_2", uo_out, 8'd200);

        // Reset pulse mid-ramp with ena still high
        rst_n = 1'b1;
        tick(); chk("midrst", uo_out, 8'd128);
        rst_n = 1'b0;
        tick(); chk("midrst_next", uo_out, 8'd140);
        tick(); chk("uio_out_run", uio_out, 8'h00);
        chk("uio_oe_run", uio_oe, 8'h00);

        // High rail: shifted 31 clamped to 16
        do_reset();
        ui_in = 8'd255; uio_in = 8'd0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("slew_up", uo_out, 8'(128 + 16 * i));
        end
        tick(); chk("rail_hi", uo_out, 8'd255);
        tick(); chk("rail_hi_hold0", uo_out, 8'd255);
        tick(); chk("rail_hi_hold1", uo_out, 8'd255);

        // Reversing diff leaves the high rail on the next edge
        ui_in = 8'd0; uio_in = 8'd255;
        tick(); chk("rail_hi_leave", uo_out, 8'd239);

        // Low rail from 128: step -16 reaches 0 exactly on the 8th edge
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("slew_dn", uo_out, 8'(128 - 16 * i));
        end
        tick(); chk("rail_lo_hold", uo_out, 8'd0);

        // diff +1 floors to step 0
        ui_in = 8'd101; uio_in = 8'd100;
        tick(); chk("pos1_zero_0", uo_out, 8'd0);
        tick(); chk("pos1_zero_1", uo_out, 8'd0);

        // diff -1 floors to step -1
        do_reset();
        ui_in = 8'd100; uio_in = 8'd101;
        tick(); chk("neg1_0", uo_out, 8'd127);
        tick(); chk("neg1_1", uo_out, 8'd126);

        // diff -9 floors to -2; diff +15 gives +1
        ui_in = 8'd0; uio_in = 8'd9;
        tick(); chk("neg9", uo_out, 8'd124);
        ui_in = 8'd15; uio_in = 8'd0;
        tick(); chk("pos15", uo_out, 8'd125);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
